// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types, BCD limits and digit helpers for the MM:SS countdown timer
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, PAUSED, RUN, EXPIRED} state_t;
  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_t;
  localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
  localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;
  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction
  function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic [3:0] max);
    return (d == 4'd0) ? {1'b1, max} : {1'b0, d - 4'd1};
  endfunction
  // m1 never borrows: decrement is only applied to a non-zero count
  function automatic bcd_t bcd_dec(input bcd_t c);
    logic [4:0] s0, s1, m0;
    logic [3:0] m1;
    s0 = dec_digit(c.s0, DIGIT_MAX_UNITS);
    s1 = s0[4] ? dec_digit(c.s1, DIGIT_MAX_TENS) : {1'b0, c.s1};
    m0 = s1[4] ? dec_digit(c.m0, DIGIT_MAX_UNITS) : {1'b0, c.m0};
    m1 = m0[4] ? c.m1 - 4'd1 : c.m1;
    return {m1, m0[3:0], s1[3:0], s0[3:0]};
  endfunction
endpackage

// File: rtl/countdown_clock_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every TICK_DIV enabled cycles
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
  logic [CNT_W-1:0] cnt;
  assign tick = enable && cnt == LAST;
  always_ff @(posedge clk) begin
    if (!reset_n || clear || tick) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/countdown_clock.sv
// countdown_clock: loadable MM:SS BCD countdown timer with start/stop control and expiry flag
import countdown_pkg::*;
module countdown_clock #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] set_m1,
  input  logic [3:0] set_m0,
  input  logic [3:0] set_s1,
  input  logic [3:0] set_s0,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] bin3,
  output logic [3:0] bin2,
  output logic [3:0] bin1,
  output logic [3:0] bin0,
  output logic       running,
  output logic       expired,
  output logic       done
);
  state_t state, state_n;
  bcd_t count, count_n;
  logic done_n, tick, enable, clear;
  // stop suppresses a coincident tick, so the prescaler freezes on the stop edge
  assign enable = state == RUN && !stop;
  assign clear = state == PAUSED && state_n == RUN;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .tick(tick)
  );
  always_comb begin
    state_n = state;
    count_n = count;
    done_n = 1'b0;
    if (load && state != RUN) begin
      count_n = {clamp(set_m1, DIGIT_MAX_TENS), clamp(set_m0, DIGIT_MAX_UNITS),
                 clamp(set_s1, DIGIT_MAX_TENS), clamp(set_s0, DIGIT_MAX_UNITS)};
      state_n = (count_n == '0) ? IDLE : PAUSED;
    end else if (state == RUN && stop) begin
      state_n = PAUSED;
    end else if (state == PAUSED && start && !stop && count != '0) begin
      state_n = RUN;
    end else if (tick) begin
      count_n = bcd_dec(count);
      state_n = (count_n == '0) ? EXPIRED : RUN;
      done_n = count_n == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      done <= done_n;
    end
  end
  assign {bin3, bin2, bin1, bin0} = count;
  assign running = state == RUN;
  assign expired = state == EXPIRED;
endmodule

// File: tb/tb_countdown_clock.sv
// tb_countdown_clock: directed scoreboard bench for countdown_clock with TICK_DIV=4
module tb_countdown_clock;
  logic clk = 1'b0, reset_n = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] set_m1 = '0, set_m0 = '0, set_s1 = '0, set_s0 = '0;
  logic [3:0] bin3, bin2, bin1, bin0;
  logic running, expired, done;
  int tests = 0, fails = 0, done_cnt = 0, bcd_bad = 0, done_base;
  typedef struct {
    string tag;
    logic [18:0] val;
  } exp_t;
  exp_t sb[$];
  countdown_clock #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .set_m1(set_m1), .set_m0(set_m0),
    .set_s1(set_s1), .set_s0(set_s0), .start(start), .stop(stop), .bin3(bin3),
    .bin2(bin2), .bin1(bin1), .bin0(bin0), .running(running), .expired(expired), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (reset_n) assert (bin0 <= 9 && bin1 <= 5 && bin2 <= 9 && bin3 <= 5) else bcd_bad++;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_st(input string tag, input logic [15:0] b, input logic r, input logic e, input logic d);
    exp_t x;
    x.tag = tag;
    x.val = {b, r, e, d};
    sb.push_back(x);
  endtask
  task automatic check();
    exp_t x;
    logic [18:0] got;
    x = sb.pop_front();
    got = {bin3, bin2, bin1, bin0, running, expired, done};
    tests++;
    assert (got === x.val) else begin
      fails++;
      $error("FAIL %s: got bin=%h run/exp/done=%b required bin=%h run/exp/done=%b",
             x.tag, got[18:3], got[2:0], x.val[18:3], x.val[2:0]);
    end
  endtask
  task automatic st(input string tag, input logic [15:0] b, input logic r, input logic e, input logic d);
    expect_st(tag, b, r, e, d);
    check();
  endtask
  task automatic chk_int(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d required %0d", tag, got, want);
    end
  endtask
  task automatic do_load(input logic [15:0] v);
    {set_m1, set_m0, set_s1, set_s0} = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask
  initial begin
    cyc(2);
    reset_n = 1'b1;
    st("reset", 16'h0000, 0, 0, 0);
    do_load(16'h0100);
    st("load_0100", 16'h0100, 0, 0, 0);
    do_start();
    st("start_edge", 16'h0100, 1, 0, 0);
    cyc(3);
    st("before_tick", 16'h0100, 1, 0, 0);
    cyc(1);
    st("first_tick", 16'h0059, 1, 0, 0);
    cyc(4);
    st("second_tick", 16'h0058, 1, 0, 0);
    reset_n = 1'b0;
    cyc(1);
    st("reset_mid_run", 16'h0000, 0, 0, 0);
    reset_n = 1'b1;
    do_load(16'h1000);
    do_start();
    cyc(4);
    st("borrow_chain", 16'h0959, 1, 0, 0);
    do_stop();
    do_load(16'h0001);
    st("load_0001", 16'h0001, 0, 0, 0);
    do_start();
    cyc(3);
    st("pre_expire", 16'h0001, 1, 0, 0);
    cyc(1);
    st("expire_edge", 16'h0000, 0, 1, 1);
    cyc(1);
    st("done_one_cycle", 16'h0000, 0, 1, 0);
    cyc(8);
    st("expired_hold", 16'h0000, 0, 1, 0);
    do_load(16'h0010);
    st("load_clears_exp", 16'h0010, 0, 0, 0);
    do_start();
    cyc(1);
    do_stop();
    cyc(20);
    st("paused_frozen", 16'h0010, 0, 0, 0);
    do_start();
    cyc(3);
    st("resume_pre", 16'h0010, 1, 0, 0);
    cyc(1);
    st("resume_tick", 16'h0009, 1, 0, 0);
    cyc(3);
    do_stop();
    st("stop_on_tick", 16'h0009, 0, 0, 0);
    cyc(5);
    st("stop_tick_hold", 16'h0009, 0, 0, 0);
    do_start();
    cyc(1);
    do_load(16'h0505);
    st("load_in_run", 16'h0009, 1, 0, 0);
    do_stop();
    do_load(16'h7C9F);
    st("clamp", 16'h5959, 0, 0, 0);
    do_load(16'h0000);
    do_start();
    cyc(4);
    st("zero_idle", 16'h0000, 0, 0, 0);
    {set_m1, set_m0, set_s1, set_s0} = 16'h0005;
    load = 1'b1;
    start = 1'b1;
    cyc(1);
    load = 1'b0;
    start = 1'b0;
    st("load_start", 16'h0005, 0, 0, 0);
    cyc(8);
    st("load_start_hold", 16'h0005, 0, 0, 0);
    do_load(16'h5959);
    done_base = done_cnt;
    do_start();
    cyc(3599 * 4 - 1);
    st("long_pre", 16'h0001, 1, 0, 0);
    cyc(1);
    st("long_expire", 16'h0000, 0, 1, 1);
    cyc(4);
    st("long_final", 16'h0000, 0, 1, 0);
    chk_int("long_done_pulses", done_cnt - done_base, 1);
    chk_int("bcd_range", bcd_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
